// File: rtl/dmux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmux_pkg
// Description : Shared channel count, FSM state type and one-hot decode helper
//               for the 1-to-4 demux dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package dmux_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Map a 2-bit channel select to its one-hot channel valid pattern
  function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] s);
    logic [NUM_CH-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational rotating-priority picker over four requesters.
//               Returns the first set mask bit searching upward from last+1,
//               wrapping 3->0; 'any' flags that at least one bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
  import dmux_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);

  // Scan from the farthest candidate back to the nearest so the nearest wins
  always_comb begin
    pick = '0;
    any  = |mask;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (mask[last + 2'(k)]) begin
        pick = last + 2'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmux_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : dmux_dispatcher
// Description : Sequencing controller for a 1-to-4 demux. Accepts words over
//               valid/ready, picks a channel (round-robin over enabled
//               channels or a fixed channel), holds the word and presents it
//               one-hot on the selected channel until that consumer is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_dispatcher
  import dmux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [1:0]        fixed_sel,
  input  logic [3:0]        ch_mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt
);

  state_t            r_state;
  logic [DATA_W-1:0] r_hold;
  logic [1:0]        r_sel;
  logic [1:0]        r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_out_valid;
  logic              r_busy;

  logic [1:0]        w_last_eff;
  logic [1:0]        w_rr_pick;
  logic              w_rr_any;
  logic [1:0]        w_pick;
  logic              w_can_route;
  logic              w_done;
  logic              w_accept;

  // While a word is held it is either completing this edge or blocking any
  // accept, so its channel is the effective last grant for the next pick.
  // This keeps back-to-back round-robin rotating on consecutive cycles.
  assign w_last_eff = (r_state == SEND) ? r_sel : r_last;

  rr_pick4 u_rr_pick4 (
    .mask (ch_mask),
    .last (w_last_eff),
    .pick (w_rr_pick),
    .any  (w_rr_any)
  );

  // Routing feasibility and channel pick for the next accepted word
  always_comb begin
    w_can_route = 1'b0;
    w_pick      = 2'd0;
    if (mode) begin
      w_can_route = ch_mask[fixed_sel];
      w_pick      = fixed_sel;
    end else begin
      w_can_route = w_rr_any;
      w_pick      = w_rr_pick;
    end
  end

  // Completion ignores ready from every channel except the held one
  assign w_done   = (r_state == SEND) && out_ready[r_sel];
  assign in_ready = rst_n && en && w_can_route && ((r_state == IDLE) || w_done);
  assign w_accept = in_valid && in_ready;

  // Dispatch FSM with hold register, last grant and completed-transfer count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_sel       <= 2'd0;
      r_last      <= 2'd3;
      r_cnt       <= '0;
      r_out_valid <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_done) begin
        r_last <= r_sel;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_state     <= SEND;
        r_hold      <= in_data;
        r_sel       <= w_pick;
        r_out_valid <= onehot4(w_pick);
        r_busy      <= 1'b1;
      end else if (w_done) begin
        // Hold register keeps its value so out_data stays put while idle
        r_state     <= IDLE;
        r_out_valid <= '0;
        r_busy      <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_hold;
  assign sel       = r_sel;
  assign busy      = r_busy;
  assign xfer_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmux_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux_dispatcher
// Description : Directed self-checking bench for dmux_dispatcher. A narrow
//               transfer counter makes the wrap-around reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux_dispatcher;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              mode;
  logic [1:0]        fixed_sel;
  logic [3:0]        ch_mask;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_ready;
  logic [1:0]        sel;
  logic              busy;
  logic [CNT_W-1:0]  xfer_cnt;

  int n_cmp;
  int n_err;

  dmux_dispatcher #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .fixed_sel (fixed_sel),
    .ch_mask   (ch_mask),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; fixed_sel = 2'd0; ch_mask = 4'b1111;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 4'b1111;
    step(); step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0000", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
    n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL rst_sel got=%0d exp=0", sel); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (xfer_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", xfer_cnt); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_rr_full();
    logic [3:0] exp_ov [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] d;
    ch_mask = 4'b1111; out_ready = 4'b1111; mode = 1'b0;
    in_valid = 1'b1; in_data = 8'h10;
    for (int i = 0; i < 8; i++) begin
      step();
      d = 8'h10 + 8'(i);
      n_cmp++; if (out_valid !== exp_ov[i]) begin n_err++; $display("FAIL rr_full_ov[%0d] got=%b exp=%b", i, out_valid, exp_ov[i]); end
      n_cmp++; if (out_data !== d) begin n_err++; $display("FAIL rr_full_data[%0d] got=%h exp=%h", i, out_data, d); end
      in_data = d + 8'h01;
      if (i == 7) in_valid = 1'b0;
    end
    step();
    n_cmp++; if (xfer_cnt !== 4'd8) begin n_err++; $display("FAIL rr_full_cnt got=%0d exp=8", xfer_cnt); end
    n_cmp++; if (busy !== 1'b0 || out_valid !== 4'b0000) begin n_err++; $display("FAIL rr_full_idle busy=%b ov=%b exp=0/0000", busy, out_valid); end
    n_cmp++; if (out_data !== 8'h17) begin n_err++; $display("FAIL rr_full_hold_data got=%h exp=17", out_data); end
  endtask

  task automatic test_rr_mask();
    logic [3:0] exp_ov [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    ch_mask = 4'b1010; in_valid = 1'b1; in_data = 8'h20;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (out_valid !== exp_ov[i]) begin n_err++; $display("FAIL rr_mask_ov[%0d] got=%b exp=%b", i, out_valid, exp_ov[i]); end
      n_cmp++; if (out_data !== 8'h20 + 8'(i)) begin n_err++; $display("FAIL rr_mask_data[%0d] got=%h exp=%h", i, out_data, 8'h20 + 8'(i)); end
      in_data = 8'h21 + 8'(i);
      if (i == 3) in_valid = 1'b0;
    end
    step();
    n_cmp++; if (xfer_cnt !== 4'd12) begin n_err++; $display("FAIL rr_mask_cnt got=%0d exp=12", xfer_cnt); end
  endtask

  task automatic test_stall();
    mode = 1'b1; fixed_sel = 2'd2; ch_mask = 4'b1111; out_ready = 4'b1011;
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 4'b0100 || out_data !== 8'hA5) begin n_err++; $display("FAIL stall_hold[%0d] ov=%b data=%h exp=0100/a5", i, out_valid, out_data); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
      step();
    end
    n_cmp++; if (xfer_cnt !== 4'd12) begin n_err++; $display("FAIL stall_cnt_held got=%0d exp=12", xfer_cnt); end
    out_ready = 4'b1111;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    step();
    n_cmp++; if (busy !== 1'b0 || xfer_cnt !== 4'd13) begin n_err++; $display("FAIL stall_complete busy=%b cnt=%0d exp=0/13", busy, xfer_cnt); end
  endtask

  task automatic test_cant_route();
    mode = 1'b1; fixed_sel = 2'd1; ch_mask = 4'b1101; out_ready = 4'b1111;
    in_valid = 1'b1; in_data = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL no_route[%0d] ready=%b busy=%b exp=0/0", i, in_ready, busy); end
    end
    ch_mask = 4'b1111;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL route_enable_ready got=%b exp=1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 4'b0010 || out_data !== 8'h33) begin n_err++; $display("FAIL route_accept ov=%b data=%h exp=0010/33", out_valid, out_data); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (xfer_cnt !== 4'd14) begin n_err++; $display("FAIL route_cnt got=%0d exp=14", xfer_cnt); end
  endtask

  task automatic test_mask_change();
    mode = 1'b0; ch_mask = 4'b1111; out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 8'h44;
    step();
    n_cmp++; if (out_valid !== 4'b0100 || sel !== 2'd2) begin n_err++; $display("FAIL mchg_first ov=%b sel=%0d exp=0100/2", out_valid, sel); end
    ch_mask = 4'b0001; in_data = 8'h55;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (out_valid !== 4'b0100 || out_data !== 8'h44 || in_ready !== 1'b0) begin n_err++; $display("FAIL mchg_hold[%0d] ov=%b data=%h rdy=%b exp=0100/44/0", i, out_valid, out_data, in_ready); end
    end
    out_ready = 4'b1111;
    step();
    n_cmp++; if (out_valid !== 4'b0001 || out_data !== 8'h55) begin n_err++; $display("FAIL mchg_next ov=%b data=%h exp=0001/55", out_valid, out_data); end
    n_cmp++; if (xfer_cnt !== 4'd15) begin n_err++; $display("FAIL mchg_cnt got=%0d exp=15", xfer_cnt); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (xfer_cnt !== 4'd0) begin n_err++; $display("FAIL cnt_wrap got=%0d exp=0", xfer_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mchg_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0; ch_mask = 4'b1111; out_ready = 4'b1111;
    in_valid = 1'b1; in_data = 8'h66;
    step();
    n_cmp++; if (out_valid !== 4'b0010) begin n_err++; $display("FAIL rmid_pick1 got=%b exp=0010", out_valid); end
    in_data = 8'h77; out_ready = 4'b0000;
    #0;
    out_ready = 4'b0010;
    step();
    n_cmp++; if (out_valid !== 4'b0100 || out_data !== 8'h77 || xfer_cnt !== 4'd1) begin n_err++; $display("FAIL rmid_held ov=%b data=%h cnt=%0d exp=0100/77/1", out_valid, out_data, xfer_cnt); end
    in_valid = 1'b0; out_ready = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 4'b0000 || busy !== 1'b0 || xfer_cnt !== 4'd0) begin n_err++; $display("FAIL rmid_clear ov=%b busy=%b cnt=%0d exp=0000/0/0", out_valid, busy, xfer_cnt); end
    n_cmp++; if (in_ready !== 1'b0 || out_data !== 8'h00) begin n_err++; $display("FAIL rmid_clear2 rdy=%b data=%h exp=0/00", in_ready, out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h88; out_ready = 4'b1111;
    step();
    n_cmp++; if (out_valid !== 4'b0001 || out_data !== 8'h88) begin n_err++; $display("FAIL rmid_first_pick ov=%b data=%h exp=0001/88", out_valid, out_data); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (xfer_cnt !== 4'd1 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_done cnt=%0d busy=%b exp=1/0", xfer_cnt, busy); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_rr_full();
    test_rr_mask();
    test_stall();
    test_cant_route();
    test_mask_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
